// File: rtl/seg_scan_ctrl_pkg.sv
// Shared definitions for the 7-segment scan controller: FSM encoding and BCD limits.
package seg_scan_ctrl_pkg;

   // Scan FSM states: BLANK holds all digits dark, SHOW drives one digit.
   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_SHOW  = 1'b1
   } scan_state_e;

   // Largest legal BCD digit; anything above is treated as undisplayable.
   localparam logic [3:0] BCD_MAX = 4'd9;

   function automatic logic bcd_invalid(input logic [3:0] nib);
      return nib > BCD_MAX;
   endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Host/display-side signal bundle of the scan controller.
// master = value source (timer logic), slave = seg_scan_ctrl.
interface seg_scan_if #(
   parameter int DIGITS = 4
);
   logic                  upd;
   logic [4*DIGITS-1:0]   digits_in;
   logic                  lz_en;
   logic [3:0]            num;
   logic                  seg_en;
   logic [DIGITS-1:0]     dig_sel;
   logic                  frame_done;

   modport master (
      output upd, digits_in, lz_en,
      input  num, seg_en, dig_sel, frame_done
   );

   modport slave (
      input  upd, digits_in, lz_en,
      output num, seg_en, dig_sel, frame_done
   );
endinterface

// File: rtl/seg_scan_ctrl_slot_timer.sv
// Free-running slot position counter with strobes marking the blank end,
// the last-but-one slot cycle and the final slot cycle.
module scan_slot_timer #(
   parameter int SCAN_DIV  = 50000,
   parameter int BLANK_CYC = 1000,
   localparam int CNT_W    = $clog2(SCAN_DIV)
) (
   input  logic clk,
   input  logic rst_n,
   output logic blank_end,
   output logic pre_end,
   output logic slot_end
);
   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] cnt_next;

   assign blank_end = (cnt_reg == CNT_W'(BLANK_CYC - 1));
   assign pre_end   = (cnt_reg == CNT_W'(SCAN_DIV - 2));
   assign slot_end  = (cnt_reg == CNT_W'(SCAN_DIV - 1));

   // Next slot position: wrap to 0 after the last cycle of the slot.
   always_comb begin
      cnt_next = cnt_reg + CNT_W'(1);
      if (slot_end)
         cnt_next = '0;
   end

   // Slot position register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_reg <= '0;
      else
         cnt_reg <= cnt_next;
   end
endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with double-buffered value,
// inter-digit blanking and optional leading-zero suppression.
module seg_scan_ctrl
   import seg_scan_ctrl_pkg::*;
#(
   parameter int DIGITS    = 4,
   parameter int SCAN_DIV  = 50000,
   parameter int BLANK_CYC = 1000
) (
   input logic       clk,
   input logic       rst_n,
   seg_scan_if.slave bus
);
   localparam int              IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

   scan_state_e          state_reg, state_next;
   logic [IDX_W-1:0]     idx_reg, idx_next;
   logic [4*DIGITS-1:0]  stage_reg, shadow_reg;
   logic [3:0]           num_reg, num_next;
   logic                 seg_en_reg, seg_en_next;
   logic [DIGITS-1:0]    dig_sel_reg, dig_sel_next;
   logic                 frame_done_reg, frame_done_next;

   logic                 blank_end, pre_end, slot_end;
   logic [3:0]           nib_arr [DIGITS];
   logic [DIGITS-1:0]    upper_zero;
   logic [3:0]           cur_nib;
   logic                 suppress;

   scan_slot_timer #(
      .SCAN_DIV  (SCAN_DIV),
      .BLANK_CYC (BLANK_CYC)
   ) u_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .blank_end (blank_end),
      .pre_end   (pre_end),
      .slot_end  (slot_end)
   );

   // upper_zero[i]: every shadow nibble from i up to the most significant is 0.
   for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
      assign nib_arr[gi]    = shadow_reg[4*gi +: 4];
      assign upper_zero[gi] = ~|shadow_reg[4*DIGITS-1:4*gi];
   end

   assign cur_nib  = nib_arr[idx_reg];
   assign suppress = bcd_invalid(cur_nib) ||
                     (bus.lz_en && (idx_reg != '0) && upper_zero[idx_reg]);

   // Next-state and next-output logic; outputs are precomputed so they
   // register together and select/data never disagree.
   always_comb begin
      state_next      = state_reg;
      idx_next        = idx_reg;
      num_next        = 4'd0;
      seg_en_next     = 1'b0;
      dig_sel_next    = '0;
      frame_done_next = pre_end && (idx_reg == IDX_LAST);
      case (state_reg)
         ST_BLANK: if (blank_end) state_next = ST_SHOW;
         ST_SHOW: begin
            if (slot_end) begin
               state_next = ST_BLANK;
               idx_next   = (idx_reg == IDX_LAST) ? '0 : idx_reg + IDX_W'(1);
            end
         end
         default: state_next = ST_BLANK;
      endcase
      if (state_next == ST_SHOW) begin
         dig_sel_next = DIGITS'(1) << idx_reg;
         num_next     = cur_nib;
         seg_en_next  = !suppress;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_reg <= ST_BLANK;
      else
         state_reg <= state_next;
   end

   // Digit index, value buffers and registered outputs; shadow takes the
   // staged value on the frame_done cycle so a frame is never torn.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_reg        <= '0;
         stage_reg      <= '0;
         shadow_reg     <= '0;
         num_reg        <= 4'd0;
         seg_en_reg     <= 1'b0;
         dig_sel_reg    <= '0;
         frame_done_reg <= 1'b0;
      end else begin
         idx_reg        <= idx_next;
         if (bus.upd)
            stage_reg  <= bus.digits_in;
         if (frame_done_reg)
            shadow_reg <= stage_reg;
         num_reg        <= num_next;
         seg_en_reg     <= seg_en_next;
         dig_sel_reg    <= dig_sel_next;
         frame_done_reg <= frame_done_next;
      end
   end

   assign bus.num        = num_reg;
   assign bus.seg_en     = seg_en_reg;
   assign bus.dig_sel    = dig_sel_reg;
   assign bus.frame_done = frame_done_reg;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: directed vector table, boundary sequences and
// randomized traffic, all checked against a cycle-indexed reference model.
module tb_seg_scan_ctrl;
   localparam int DIGITS    = 4;
   localparam int SCAN_DIV  = 8;
   localparam int BLANK_CYC = 2;
   localparam int FRAME     = DIGITS * SCAN_DIV;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   seg_scan_if #(.DIGITS(DIGITS)) bus();

   seg_scan_ctrl #(
      .DIGITS    (DIGITS),
      .SCAN_DIV  (SCAN_DIV),
      .BLANK_CYC (BLANK_CYC)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: t_m = cycles since reset release; values per frame.
   int          t_m;
   logic [15:0] stage_m;
   logic [15:0] shadow_m;
   logic        lz_m;

   typedef struct {
      logic [15:0] val;
      logic        lz;
      int          digit;
      logic [3:0]  num;
      logic        en;
   } vec_t;

   vec_t vecs [14];

   task automatic chk(input string name, input int t, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", name, t, act, exp);
      end
   endtask

   // Expected outputs from slot arithmetic on the cycle number.
   task automatic check_model();
      int          pos;
      int          slot;
      logic [15:0] upper;
      logic [3:0]  nib;
      logic        en;
      pos   = t_m % SCAN_DIV;
      slot  = (t_m / SCAN_DIV) % DIGITS;
      upper = shadow_m >> (4 * slot);
      nib   = upper[3:0];
      chk("frame_done", t_m, {31'd0, bus.frame_done}, {31'd0, (t_m % FRAME) == FRAME - 1});
      if (pos < BLANK_CYC) begin
         chk("blank_dig_sel", t_m, {28'd0, bus.dig_sel}, 32'd0);
         chk("blank_seg_en", t_m, {31'd0, bus.seg_en}, 32'd0);
      end else begin
         en = (nib <= 4'd9) && !(lz_m && slot != 0 && upper == 16'd0);
         chk("dig_sel", t_m, {28'd0, bus.dig_sel}, 32'(1) << slot);
         chk("num", t_m, {28'd0, bus.num}, {28'd0, nib});
         chk("seg_en", t_m, {31'd0, bus.seg_en}, {31'd0, en});
      end
   endtask

   // One cycle: check current outputs, then drive inputs for the next edge.
   task automatic step(input logic u, input logic [15:0] d, input logic lz);
      @(negedge clk);
      check_model();
      bus.upd       = u;
      bus.digits_in = d;
      bus.lz_en     = lz;
      if ((t_m % FRAME) == FRAME - 1)
         shadow_m = stage_m;
      if (u)
         stage_m = d;
      lz_m = lz;
      t_m++;
   endtask

   task automatic do_reset(input logic lz);
      rst_n         = 1'b0;
      bus.upd       = 1'b0;
      bus.digits_in = '0;
      bus.lz_en     = lz;
      #1;
      chk("rst_num", -1, {28'd0, bus.num}, 32'd0);
      chk("rst_seg_en", -1, {31'd0, bus.seg_en}, 32'd0);
      chk("rst_dig_sel", -1, {28'd0, bus.dig_sel}, 32'd0);
      chk("rst_frame_done", -1, {31'd0, bus.frame_done}, 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      t_m      = 0;
      stage_m  = '0;
      shadow_m = '0;
      lz_m     = lz;
   endtask

   function automatic logic [15:0] rand_val();
      logic [15:0] v;
      v = 16'($urandom);
      for (int k = 0; k < 4; k++)
         if ($urandom_range(2) == 0) v[4*k +: 4] = 4'h0;
      return v;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      logic [15:0] rv;
      logic        rlz;
      int          target;
      vecs[0]  = '{16'h1234, 1'b0, 0, 4'h4, 1'b1};
      vecs[1]  = '{16'h1234, 1'b0, 1, 4'h3, 1'b1};
      vecs[2]  = '{16'h1234, 1'b0, 2, 4'h2, 1'b1};
      vecs[3]  = '{16'h1234, 1'b0, 3, 4'h1, 1'b1};
      vecs[4]  = '{16'h0040, 1'b1, 3, 4'h0, 1'b0};
      vecs[5]  = '{16'h0040, 1'b1, 2, 4'h0, 1'b0};
      vecs[6]  = '{16'h0040, 1'b1, 1, 4'h4, 1'b1};
      vecs[7]  = '{16'h0040, 1'b1, 0, 4'h0, 1'b1};
      vecs[8]  = '{16'h0000, 1'b1, 3, 4'h0, 1'b0};
      vecs[9]  = '{16'h0000, 1'b1, 1, 4'h0, 1'b0};
      vecs[10] = '{16'h0000, 1'b1, 0, 4'h0, 1'b1};
      vecs[11] = '{16'h00A7, 1'b0, 1, 4'hA, 1'b0};
      vecs[12] = '{16'h00A7, 1'b0, 0, 4'h7, 1'b1};
      vecs[13] = '{16'h00A7, 1'b1, 2, 4'h0, 1'b0};

      rst_n         = 1'b1;
      bus.upd       = 1'b0;
      bus.digits_in = '0;
      bus.lz_en     = 1'b0;
      #2;

      // Table: upd at cycle 5, inspect the requested digit in frame 2.
      for (int v = 0; v < 14; v++) begin
         do_reset(vecs[v].lz);
         target = FRAME + vecs[v].digit * SCAN_DIV + BLANK_CYC + 1;
         for (int t = 0; t <= target; t++) begin
            step(t == 5, vecs[v].val, vecs[v].lz);
            if (t == target) begin
               chk("vec_dig_sel", t, {28'd0, bus.dig_sel}, 32'(1) << vecs[v].digit);
               chk("vec_num", t, {28'd0, bus.num}, {28'd0, vecs[v].num});
               chk("vec_seg_en", t, {31'd0, bus.seg_en}, {31'd0, vecs[v].en});
            end
         end
      end

      // Update coincident with frame_done: old stage shown, new one a frame later.
      do_reset(1'b0);
      for (int t = 0; t < 3 * FRAME; t++) begin
         step((t == 5) || (t == FRAME - 1), (t < 20) ? 16'h1234 : 16'h5678, 1'b0);
         if (t == FRAME + BLANK_CYC)
            chk("collide_old", t, {28'd0, bus.num}, 32'h4);
         if (t == 2 * FRAME + BLANK_CYC)
            chk("collide_new", t, {28'd0, bus.num}, 32'h8);
      end

      // Reset asserted during SHOW of digit 2, then a clean restart.
      do_reset(1'b0);
      target = FRAME + 2 * SCAN_DIV + BLANK_CYC + 2;
      for (int t = 0; t <= target; t++)
         step(t == 3, 16'h9876, 1'b0);
      chk("pre_rst_dig_sel", target, {28'd0, bus.dig_sel}, 32'h4);
      #2;
      do_reset(1'b0);
      for (int t = 0; t < FRAME + 8; t++)
         step(1'b0, 16'h0000, 1'b0);

      // Randomized traffic with lz_en toggling mid-slot.
      do_reset(1'b0);
      rlz = 1'b0;
      rv  = '0;
      for (int t = 0; t < 800; t++) begin
         if ($urandom_range(15) == 0) rlz = ~rlz;
         rv = rand_val();
         step($urandom_range(11) == 0, rv, rlz);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
